// File: rtl/pulse_scheduler_mc.sv
// pulse_scheduler_mc: multi-channel timestamp-driven pulse scheduler (per-channel FIFO, head register, issue FSM).
// Define PULSE_SCHED_LATE_DROP_EN to discard late heads instead of issuing them.
module pulse_scheduler_mc #(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIME_W     = 32,
  parameter int LEN_W      = 16,
  parameter int PAYLOAD_W  = 64,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [CH_W-1:0]             s_chan,
  input  logic [TIME_W-1:0]           s_tstart,
  input  logic [LEN_W-1:0]            s_tlen,
  input  logic [PAYLOAD_W-1:0]        s_payload,
  input  logic                        timer_en,
  input  logic                        timer_clear,
  input  logic                        err_clear,
  output logic [TIME_W-1:0]           time_now,
  output logic [NUM_CH-1:0]           m_valid,
  input  logic [NUM_CH-1:0]           m_ready,
  output logic [NUM_CH*PAYLOAD_W-1:0] m_payload,
  output logic [NUM_CH*LEN_W-1:0]     m_tlen,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_CH-1:0]           fifo_full,
  output logic [NUM_CH-1:0]           fifo_empty,
  output logic [NUM_CH-1:0]           late_err,
  output logic                        chan_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = TIME_W + LEN_W + PAYLOAD_W;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, PLAY} state_t;
  logic chan_ok;
  logic [2**CH_W-1:0] full_pad;
  assign chan_ok = {1'b0, s_chan} < (CH_W+1)'(NUM_CH);
  assign full_pad = (2**CH_W)'(fifo_full);
  assign s_ready = !chan_ok || !full_pad[s_chan];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) time_now <= '0;
    else if (timer_clear) time_now <= '0;
    else if (timer_en) time_now <= time_now + TIME_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chan_err <= 1'b0;
    else if (s_valid && !chan_ok) chan_err <= 1'b1;
    else if (err_clear) chan_err <= 1'b0;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt, cnt_n;
    logic full_q, empty_q, late_q, head_v;
    logic push, load, hs, drop, free, late_set, due, late;
    logic [TIME_W-1:0] head_ts, diff;
    logic [LEN_W-1:0] head_len, rem;
    logic [PAYLOAD_W-1:0] head_pl;
    state_t st, nxt;
    assign push = s_valid && chan_ok && s_chan == CH_W'(c) && !full_q;
    assign hs = st == ISSUE && m_ready[c];
    // Modular difference keeps early/late classification correct across time base wrap.
    assign diff = time_now - head_ts;
    assign due = diff == '0;
    assign late = !due && !diff[TIME_W-1];
    assign late_set = st == WAIT && late;
`ifdef PULSE_SCHED_LATE_DROP_EN
    assign drop = late_set;
`else
    assign drop = 1'b0;
`endif
    assign free = hs || drop;
    assign load = (!head_v || free) && !empty_q;
    assign cnt_n = cnt + (AW+1)'(push) - (AW+1)'(load);
    always_ff @(posedge clk)
      if (push) mem[wp] <= {s_tstart, s_tlen, s_payload};
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        full_q <= 1'b0;
        empty_q <= 1'b1;
      end else begin
        wp <= wp + AW'(push);
        rp <= rp + AW'(load);
        cnt <= cnt_n;
        full_q <= cnt_n == (AW+1)'(FIFO_DEPTH);
        empty_q <= cnt_n == '0;
      end
    // Head refills on the same edge it is freed so back-to-back pulses lose no cycle.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        head_v <= 1'b0;
        head_ts <= '0;
        head_len <= '0;
        head_pl <= '0;
      end else if (load) begin
        head_v <= 1'b1;
        {head_ts, head_len, head_pl} <= mem[rp];
      end else if (free) head_v <= 1'b0;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st <= IDLE;
        rem <= '0;
      end else begin
        st <= nxt;
        rem <= hs ? head_len : st == PLAY ? rem - LEN_W'(1) : rem;
      end
    always_comb begin
      nxt = st;
      case (st)
        IDLE:    nxt = head_v ? WAIT : IDLE;
        WAIT:    nxt = due ? ISSUE : !late ? WAIT : drop ? (empty_q ? IDLE : WAIT) : ISSUE;
        ISSUE:   nxt = !m_ready[c] ? ISSUE : head_len != '0 ? PLAY : empty_q ? IDLE : WAIT;
        PLAY:    nxt = rem != LEN_W'(1) ? PLAY : head_v ? WAIT : IDLE;
        default: nxt = IDLE;
      endcase
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) late_q <= 1'b0;
      else if (late_set) late_q <= 1'b1;
      else if (err_clear) late_q <= 1'b0;
    assign m_valid[c] = st == ISSUE;
    assign busy[c] = st == PLAY;
    assign m_payload[c*PAYLOAD_W +: PAYLOAD_W] = head_pl;
    assign m_tlen[c*LEN_W +: LEN_W] = head_len;
    assign fifo_full[c] = full_q;
    assign fifo_empty[c] = empty_q;
    assign late_err[c] = late_q;
  end
endmodule
